ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Multi-cycle RV32M execution unit that sits beside the ALU in the EX stage of the 5-stage pipeline. It executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on the forwarded EX operands. While it works it holds the ID/EX register and the front end through a stall request, then delivers a single-cycle `done` with the result for capture into EX/MEM. Width and multiplier throughput are parametrised, and divide special cases complete on a fast path.

## Interface

Parameters:
- `XLEN`, 32, operand/result width; even, ≥8.
- `MUL_UNROLL`, 1, multiplier bits retired per cycle; one of 1, 2, 4; must divide `XLEN`.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: ID/EX holds an M-extension op (opcode 0110011, funct7 0000001); level, held by the pipeline while stalled.
- `funct3` in 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `operand_a` in XLEN: rs1 value, post-forwarding.
- `operand_b` in XLEN: rs2 value, post-forwarding.
- `rd_in` in 5: destination register of the op.
- `flush` in 1: kill any in-flight op (branch/jump redirect).
- `result` out XLEN: registered result, valid when `done`=1, held until next `done`.
- `rd_out` out 5: registered destination, paired with `result`.
- `done` out 1: registered one-cycle completion pulse.
- `busy` out 1: state is RUN.
- `stall_req` out 1: combinational; `(IDLE & start & !flush) | RUN`.

## Operation

- States are IDLE, RUN and DONE.
- IDLE:
  - `flush`=1: stay IDLE.
  - `start`=1 and the op is a divide special case: latch the result and go to DONE.
  - `start`=1 otherwise: latch `funct3`, `rd_in`, operand magnitudes and result sign; load the counter; go to RUN.
- RUN:
  - Counter decrements each cycle.
  - On the last iteration, apply sign correction, register `result`/`rd_out`, go to DONE.
  - `flush`=1 in RUN: go to IDLE next edge; no `done`; `result`/`rd_out` keep their old values.
- DONE:
  - `done`=1 and `stall_req`=0, so the pipeline advances this cycle.
  - Next edge: go to IDLE. `start` is ignored in DONE, so the same op is never re-accepted.
  - `flush` in DONE is don't-care: the result is already delivered and EX/MEM flush is the hazard unit's job.
- Multiply:
  - Unsigned shift-add of magnitudes into a 2·XLEN product, `MUL_UNROLL` bits per cycle.
  - MUL takes product[XLEN-1:0]; MULH/MULHSU/MULHU take product[2XLEN-1:XLEN].
  - Signedness: MULH both operands signed; MULHSU a signed, b unsigned; MULHU both unsigned.
  - Negate the full 2·XLEN product when the result sign is negative.
- Divide:
  - Restoring divide of magnitudes, 1 quotient bit per cycle.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a); unsigned ops have no correction.
- Fast-path special cases (no RUN):
  - b=0: DIV/DIVU give all-ones; REM/REMU give `operand_a`.
  - Signed overflow (DIV/REM, a = −2^(XLEN−1), b = −1): quotient is a, remainder is 0.
- Reset: state IDLE; `result`, `rd_out`, counter and datapath registers cleared to 0; `done`=0, `busy`=0, so `stall_req`=`start & !flush`.

## Timing

- Start is accepted at the edge ending cycle t (IDLE, `start`=1, `flush`=0).
- Multiply: RUN occupies XLEN/MUL_UNROLL cycles; `done` in cycle t+XLEN/MUL_UNROLL+1. With defaults, t+33.
- Divide: RUN occupies XLEN cycles; `done` in t+XLEN+1.
- Special case: `done` in t+1.
- `stall_req` is high from cycle t through the cycle before `done`, and low in the `done` cycle.
- Back-to-back: a new `start` in the cycle after `done` is accepted. Issue interval is latency+1.
- `flush` in RUN at cycle f: `busy`=0 at f+1; a `start` at f+1 is accepted.
- Asynchronous `rst` mid-op: outputs take reset values immediately; no `done` is produced for the killed op.

## Test plan

- MUL, a=7, b=0xFFFFFFFD (−3), rd=5, defaults → `done` at t+33, `result`=0xFFFFFFEB, `rd_out`=5, `stall_req`=1 for cycles t..t+32.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH on the same operands → 0x00000000. MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD at t+33. REM −7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Fast path: DIVU 0x1234/0 → 0xFFFFFFFF at t+1. REM 0x1234/0 → 0x1234. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM on the same → 0. `busy` never asserts.
- Flush of a MUL at t+10 → no `done`, `busy`=0 at t+11, `result` unchanged. A new DIVU 9/3 started at t+11 → 3 at t+44.
- `MUL_UNROLL`=4: MUL 0x10000×0x10000 → 0 at t+9, MULHU on the same → 1. Async `rst` during RUN → `result`=0, `done`=0, `busy`=0 with no clock edge.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ex_muldiv_unit                                               |
// | Description : Multi-cycle RV32M multiply/divide unit for the EX stage.     |
// |               Stalls the front end while iterating; divide special cases   |
// |               complete without iterating.                                  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module ex_muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            done,
  output logic            busy,
  output logic            stall_req
);

  localparam int               CNT_W      = $clog2(XLEN);
  localparam logic [CNT_W-1:0] c_MUL_LAST = CNT_W'(XLEN / MUL_UNROLL - 1);
  localparam logic [CNT_W-1:0] c_DIV_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  c_MIN      = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2:0]          r_op;
  logic [4:0]          r_rd;
  logic                r_neg;
  logic [2*XLEN-1:0]   r_acc;
  logic [2*XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]     r_mplier;
  logic [XLEN-1:0]     r_rem;
  logic [XLEN-1:0]     r_quo;
  logic [XLEN-1:0]     r_div;
  logic [XLEN-1:0]     r_result;
  logic [4:0]          r_rd_out;
  logic                r_done;

  // Operand decode at issue time.
  logic                w_is_div;
  logic                w_a_signed;
  logic                w_b_signed;
  logic                w_sign_a;
  logic                w_sign_b;
  logic                w_neg;
  logic [XLEN-1:0]     w_mag_a;
  logic [XLEN-1:0]     w_mag_b;
  logic                w_b_zero;
  logic                w_ovf;
  logic                w_special;
  logic [XLEN-1:0]     w_special_res;

  assign w_is_div   = funct3[2];
  assign w_a_signed = w_is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign w_b_signed = w_is_div ? ~funct3[0] : ~funct3[1];
  assign w_sign_a   = w_a_signed & operand_a[XLEN-1];
  assign w_sign_b   = w_b_signed & operand_b[XLEN-1];
  assign w_mag_a    = w_sign_a ? -operand_a : operand_a;
  assign w_mag_b    = w_sign_b ? -operand_b : operand_b;
  // Remainder follows the dividend sign; everything else is sign(a)^sign(b).
  assign w_neg      = (w_is_div & funct3[1]) ? w_sign_a : (w_sign_a ^ w_sign_b);

  assign w_b_zero   = (operand_b == '0);
  assign w_ovf      = ~funct3[0] & (operand_a == c_MIN) & (operand_b == '1);
  assign w_special  = w_is_div & (w_b_zero | w_ovf);

  always_comb begin
    w_special_res = '0;
    if (w_b_zero) begin
      w_special_res = funct3[1] ? operand_a : '1;
    end else begin
      w_special_res = funct3[1] ? '0 : operand_a;
    end
  end

  // One iteration of each datapath; only the one matching r_op is used.
  logic [2*XLEN-1:0]   w_acc_nxt;
  logic [XLEN:0]       w_rem_sh;
  logic [XLEN:0]       w_diff;
  logic                w_fits;
  logic [XLEN-1:0]     w_rem_nxt;
  logic [XLEN-1:0]     w_quo_nxt;

  always_comb begin
    w_acc_nxt = r_acc;
    for (int j = 0; j < MUL_UNROLL; j++) begin
      if (r_mplier[j]) begin
        w_acc_nxt = w_acc_nxt + (r_mcand << j);
      end
    end
  end

  assign w_rem_sh  = {r_rem, r_quo[XLEN-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_div};
  assign w_fits    = ~w_diff[XLEN];
  assign w_rem_nxt = w_fits ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
  assign w_quo_nxt = {r_quo[XLEN-2:0], w_fits};

  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_final;

  always_comb begin
    w_prod  = r_neg ? -w_acc_nxt : w_acc_nxt;
    w_final = '0;
    if (r_op[2]) begin
      if (r_op[1]) begin
        w_final = r_neg ? -w_rem_nxt : w_rem_nxt;
      end else begin
        w_final = r_neg ? -w_quo_nxt : w_quo_nxt;
      end
    end else if (r_op[1:0] == 2'b00) begin
      w_final = w_prod[XLEN-1:0];
    end else begin
      w_final = w_prod[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_rd     <= '0;
      r_neg    <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_result <= '0;
      r_rd_out <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !flush) begin
            if (w_special) begin
              r_result <= w_special_res;
              r_rd_out <= rd_in;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_op     <= funct3;
              r_rd     <= rd_in;
              r_neg    <= w_neg;
              r_acc    <= '0;
              r_mcand  <= {{XLEN{1'b0}}, w_mag_a};
              r_mplier <= w_mag_b;
              r_rem    <= '0;
              r_quo    <= w_mag_a;
              r_div    <= w_mag_b;
              r_cnt    <= w_is_div ? c_DIV_LAST : c_MUL_LAST;
              r_state  <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << MUL_UNROLL;
            r_mplier <= r_mplier >> MUL_UNROLL;
            r_rem    <= w_rem_nxt;
            r_quo    <= w_quo_nxt;
            r_cnt    <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
              r_result <= w_final;
              r_rd_out <= r_rd;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        // start is ignored here so the op still held in ID/EX is not re-issued.
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign result    = r_result;
  assign rd_out    = r_rd_out;
  assign done      = r_done;
  assign busy      = (r_state == S_RUN);
  assign stall_req = ((r_state == S_IDLE) & start & ~flush) | busy;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ex_muldiv_unit                                            |
// | Description : Scoreboard bench for ex_muldiv_unit, unroll 1 and unroll 4.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, start0, flush0, done0, busy0, stall0;
  logic [2:0]  f0;
  logic [31:0] a0, b0, res0;
  logic [4:0]  rd0, rdo0;
  logic        rst1, start1, flush1, done1, busy1, stall1;
  logic [2:0]  f1;
  logic [31:0] a1, b1, res1;
  logic [4:0]  rd1, rdo1;

  ex_muldiv_unit #(.XLEN(32), .MUL_UNROLL(1)) u_dut0 (
    .clk(clk), .rst(rst0), .start(start0), .funct3(f0), .operand_a(a0), .operand_b(b0),
    .rd_in(rd0), .flush(flush0), .result(res0), .rd_out(rdo0), .done(done0),
    .busy(busy0), .stall_req(stall0));

  ex_muldiv_unit #(.XLEN(32), .MUL_UNROLL(4)) u_dut1 (
    .clk(clk), .rst(rst1), .start(start1), .funct3(f1), .operand_a(a1), .operand_b(b1),
    .rd_in(rd1), .flush(flush1), .result(res1), .rd_out(rdo1), .done(done1),
    .busy(busy1), .stall_req(stall1));

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] last_res0 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: RV32M semantics via 64-bit integer arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa, sb, ubs;
    logic [63:0] ua, ub, p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ubs = longint'(ub);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (f)
      3'd0: begin p = sa * sb;  return p[31:0];  end
      3'd1: begin p = sa * sb;  return p[63:32]; end
      3'd2: begin p = sa * ubs; return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input int unroll, input logic [2:0] f,
                                 input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 32 / unroll + 1;
    if (b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      4: return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op just after a clock edge, hold start until done, then drop it.
  task automatic run_op(input int u, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int gap);
    exp_t e;
    bit   got;
    e.res = ref_op(f, a, b);
    e.rd  = rd;
    e.cyc = cyc + latency((u == 0) ? 1 : 4, f, a, b);
    if (u == 0) begin
      q0.push_back(e); last_res0 = e.res;
      f0 = f; a0 = a; b0 = b; rd0 = rd; start0 = 1'b1;
    end else begin
      q1.push_back(e);
      f1 = f; a1 = a; b1 = b; rd1 = rd; start1 = 1'b1;
    end
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if ((u == 0) ? done0 : done1) begin
        got = 1'b1;
        break;
      end
      check((u == 0) ? "u0_stall_req" : "u1_stall_req", (u == 0) ? stall0 : stall1, 1);
      check((u == 0) ? "u0_busy" : "u1_busy", (u == 0) ? busy0 : busy1, (k == 0) ? 0 : 1);
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: unit %0d op %0d gave no done in 100 cycles", u, f);
    end
    @(posedge clk);
    #1;
    if (u == 0) start0 = 1'b0; else start1 = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (done0) begin
      if (q0.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL u0_unexpected_done: actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check("u0_result", res0, e.res);
        check("u0_rd_out", rdo0, e.rd);
        check("u0_done_cycle", 64'(cyc), 64'(e.cyc));
        check("u0_stall_in_done", stall0, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL u1_unexpected_done: actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("u1_result", res1, e.res);
        check("u1_rd_out", rdo1, e.rd);
        check("u1_done_cycle", 64'(cyc), 64'(e.cyc));
        check("u1_stall_in_done", stall1, 0);
      end
    end
  end

  initial begin
    #900_000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    int t0;
    rst0 = 1'b1; rst1 = 1'b1; flush0 = 1'b0; flush1 = 1'b0;
    start0 = 1'b1; start1 = 1'b0;
    f0 = '0; a0 = '0; b0 = '0; rd0 = '0;
    f1 = '0; a1 = '0; b1 = '0; rd1 = '0;
    repeat (2) @(negedge clk);
    check("rst_result", res0, 0);
    check("rst_rd_out", rdo0, 0);
    check("rst_done", done0, 0);
    check("rst_busy", busy0, 0);
    check("rst_stall_follows_start", stall0, 1);
    check("rst_stall_idle", stall1, 0);
    start0 = 1'b0;
    @(posedge clk); #1;
    rst0 = 1'b0; rst1 = 1'b0;
    @(posedge clk); #1;

    run_op(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0);
    run_op(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1);
    run_op(0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0);
    run_op(0, 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 0);
    run_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 0);
    run_op(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 0);
    run_op(0, 3'd5, 32'd100, 32'd7, 5'd7, 0);
    run_op(0, 3'd7, 32'd100, 32'd7, 5'd8, 0);
    run_op(0, 3'd5, 32'h1234, 32'd0, 5'd9, 0);
    run_op(0, 3'd6, 32'h1234, 32'd0, 5'd10, 0);
    run_op(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
    run_op(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);

    // Flush a multiply ten cycles in; no done, result held, next op accepted.
    t0 = cyc;
    f0 = 3'd0; a0 = 32'd3; b0 = 32'd5; rd0 = 5'd13; start0 = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    flush0 = 1'b1; start0 = 1'b0;
    @(posedge clk); #1;
    flush0 = 1'b0;
    check("flush_busy", busy0, 0);
    check("flush_result_held", res0, last_res0);
    check("flush_cycle", 64'(cyc), 64'(t0 + 11));
    run_op(0, 3'd5, 32'd9, 32'd3, 5'd14, 0);

    for (int i = 0; i < 120; i++) begin
      run_op(0, 3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(),
             5'($urandom_range(0, 31)), $urandom_range(0, 2));
    end

    for (int i = 0; i < 60; i++) begin
      run_op(1, 3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(),
             5'($urandom_range(0, 31)), $urandom_range(0, 2));
    end
    run_op(1, 3'd0, 32'h1_0000, 32'h1_0000, 5'd20, 0);
    run_op(1, 3'd3, 32'h1_0000, 32'h1_0000, 5'd21, 1);

    // Asynchronous reset in the middle of RUN.
    f1 = 3'd3; a1 = 32'hFFFF_0000; b1 = 32'h0001_0003; rd1 = 5'd22; start1 = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    #1;
    rst1 = 1'b1;
    #1;
    check("async_rst_result", res1, 0);
    check("async_rst_rd_out", rdo1, 0);
    check("async_rst_done", done1, 0);
    check("async_rst_busy", busy1, 0);
    start1 = 1'b0;
    @(posedge clk); #1;
    rst1 = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("u0_queue_drained", 64'(q0.size()), 0);
    check("u1_queue_drained", 64'(q1.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
